// File: rtl/spi_rx_slave_mc_if.sv
// Valid/ready word stream carrying a received SPI word, its select index and a
// first-of-frame flag from the receive slave to a downstream formatter.
interface spi_rx_slave_mc_if #(
  parameter int WORD_W = 8,
  parameter int CHAN_W = 1
);
  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] data;
  logic [CHAN_W-1:0] chan;
  logic              first;

  modport master (output valid, data, chan, first, input ready);
  modport slave  (input valid, data, chan, first, output ready);
endinterface

// File: rtl/spi_rx_slave_mc.sv
// Multi-select SPI mode-0 receive slave: oversamples SCK/MOSI/selects in the
// CLOCK_50 domain, assembles tagged words and buffers them in an FWFT FIFO.
module spi_rx_slave_mc #(
  parameter int NUM_SEL     = 2,
  parameter int WORD_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  localparam int CHAN_W     = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLOCK_50,
  input  logic               rst_n,
  input  logic               sck,
  input  logic               mosi,
  input  logic [NUM_SEL-1:0] ssel_n,
  spi_rx_slave_mc_if.master  m,
  output logic               frame_done,
  output logic [CHAN_W-1:0]  frame_chan,
  output logic               frame_partial,
  output logic               sel_err,
  output logic               ovf,
  input  logic               ovf_clr,
  output logic [LVL_W-1:0]   fifo_level
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BCNT_W = $clog2(WORD_W);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERROR} state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CHAN_W-1:0] chan;
    logic              first;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus an aligned/previous pair for edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0]              sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]              mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0][NUM_SEL-1:0] ssel_sync_q, ssel_sync_d;
  logic                                sck_q, sck_d, sck_prev_q, sck_prev_d;
  logic                                mosi_q, mosi_d;
  logic [NUM_SEL-1:0]                  ssel_q, ssel_d;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ssel_sync_d = {ssel_sync_q[SYNC_STAGES-2:0], ssel_n};
    sck_d       = sck_sync_q[SYNC_STAGES-1];
    sck_prev_d  = sck_q;
    mosi_d      = mosi_sync_q[SYNC_STAGES-1];
    ssel_d      = ssel_sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ssel_sync_q <= '1;
      sck_q       <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_q      <= 1'b0;
      ssel_q      <= '1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ssel_sync_q <= ssel_sync_d;
      sck_q       <= sck_d;
      sck_prev_q  <= sck_prev_d;
      mosi_q      <= mosi_d;
      ssel_q      <= ssel_d;
    end
  end

  logic               sck_rise;
  logic [NUM_SEL-1:0] sel_low;
  logic               one_low, multi_low;
  logic [CHAN_W-1:0]  sel_idx;

  assign sck_rise  = sck_q & ~sck_prev_q;
  assign sel_low   = ~ssel_q;
  assign one_low   = ($countones(sel_low) == 1);
  assign multi_low = ($countones(sel_low) > 1);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (sel_low[i]) sel_idx = CHAN_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM and word assembly
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [WORD_W-1:0] shift_q, shift_d, shift_in;
  logic              first_q, first_d;
  logic              push_q, push_d;
  entry_t            push_entry_q, push_entry_d;
  logic              frame_done_q, frame_done_d;
  logic [CHAN_W-1:0] frame_chan_q, frame_chan_d;
  logic              frame_partial_q, frame_partial_d;
  logic              sel_err_q, sel_err_d;

  always_comb begin
    if (MSB_FIRST != 0) shift_in = {shift_q[WORD_W-2:0], mosi_q};
    else                shift_in = {mosi_q, shift_q[WORD_W-1:1]};
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d         = state_q;
    chan_d          = chan_q;
    bcnt_d          = bcnt_q;
    shift_d         = shift_q;
    first_d         = first_q;
    push_d          = 1'b0;
    push_entry_d    = push_entry_q;
    frame_done_d    = 1'b0;
    frame_chan_d    = frame_chan_q;
    frame_partial_d = frame_partial_q;
    sel_err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // SCK is ignored here: in mode 0 no valid bit precedes select assertion.
        if (multi_low) begin
          state_d   = ST_ERROR;
          sel_err_d = 1'b1;
        end else if (one_low) begin
          state_d = ST_ACTIVE;
          chan_d  = sel_idx;
          bcnt_d  = '0;
          shift_d = '0;
          first_d = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (multi_low) begin
          state_d   = ST_ERROR;
          sel_err_d = 1'b1;
        end else if (ssel_q[chan_q]) begin
          state_d         = ST_IDLE;
          frame_done_d    = 1'b1;
          frame_chan_d    = chan_q;
          frame_partial_d = (bcnt_q != '0);
        end else if (sck_rise) begin
          shift_d = shift_in;
          if (bcnt_q == BCNT_W'(WORD_W - 1)) begin
            bcnt_d       = '0;
            first_d      = 1'b0;
            push_d       = 1'b1;
            push_entry_d = '{data: shift_in, chan: chan_q, first: first_q};
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      ST_ERROR: begin
        if (sel_low == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      chan_q          <= '0;
      bcnt_q          <= '0;
      shift_q         <= '0;
      first_q         <= 1'b0;
      push_q          <= 1'b0;
      push_entry_q    <= '0;
      frame_done_q    <= 1'b0;
      frame_chan_q    <= '0;
      frame_partial_q <= 1'b0;
      sel_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      chan_q          <= chan_d;
      bcnt_q          <= bcnt_d;
      shift_q         <= shift_d;
      first_q         <= first_d;
      push_q          <= push_d;
      push_entry_q    <= push_entry_d;
      frame_done_q    <= frame_done_d;
      frame_chan_q    <= frame_chan_d;
      frame_partial_q <= frame_partial_d;
      sel_err_q       <= sel_err_d;
    end
  end

  assign frame_done    = frame_done_q;
  assign frame_chan    = frame_chan_q;
  assign frame_partial = frame_partial_q;
  assign sel_err       = sel_err_q;

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  entry_t           mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop, full, wr_en;
  entry_t           head;

  assign head  = mem[rd_ptr_q];
  assign pop   = m.valid & m.ready;
  assign full  = (count_q == LVL_W'(FIFO_DEPTH));
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign wr_en = push_q & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q & ~ovf_clr) | (push_q & ~wr_en);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy and pointers alone define validity.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr_q] <= push_entry_q;
  end

  assign m.valid    = (count_q != '0);
  assign m.data     = m.valid ? head.data  : '0;
  assign m.chan     = m.valid ? head.chan  : '0;
  assign m.first    = m.valid ? head.first : 1'b0;
  assign ovf        = ovf_q;
  assign fifo_level = count_q;

endmodule

// File: tb/tb_spi_rx_slave_mc.sv
// Directed bench for spi_rx_slave_mc: frames on both selects, latency, overflow,
// partial frames, select collisions and mid-word reset.
module tb_spi_rx_slave_mc;

  localparam int NUM_SEL     = 2;
  localparam int WORD_W      = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int CHAN_W      = 1;
  localparam int LVL_W       = 5;
  localparam int HALF        = 6;

  logic               CLOCK_50 = 1'b0;
  logic               rst_n    = 1'b0;
  logic               sck      = 1'b0;
  logic               mosi     = 1'b0;
  logic               ovf_clr  = 1'b0;
  logic [NUM_SEL-1:0] ssel_n   = '1;
  logic               frame_done, frame_partial, sel_err, ovf;
  logic [CHAN_W-1:0]  frame_chan;
  logic [LVL_W-1:0]   fifo_level;

  spi_rx_slave_mc_if #(.WORD_W(WORD_W), .CHAN_W(CHAN_W)) m_if ();

  spi_rx_slave_mc #(
    .NUM_SEL(NUM_SEL), .WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH),
    .MSB_FIRST(1), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ssel_n(ssel_n),
    .m(m_if), .frame_done(frame_done), .frame_chan(frame_chan),
    .frame_partial(frame_partial), .sel_err(sel_err), .ovf(ovf),
    .ovf_clr(ovf_clr), .fifo_level(fifo_level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  logic [WORD_W-1:0] rx_data [$];
  logic [CHAN_W-1:0] rx_chan [$];
  logic              rx_first[$];
  int                fd_cnt  = 0;
  int                err_cnt = 0;
  logic [CHAN_W-1:0] fd_chan_last    = '0;
  logic              fd_partial_last = 1'b0;

  logic [7:0] pat[6] = '{8'hAA, 8'h55, 8'h00, 8'hAA, 8'h55, 8'h00};

  // Record accepted words and event pulses half a cycle away from the active edge.
  always @(negedge CLOCK_50) begin
    if (m_if.valid && m_if.ready) begin
      rx_data.push_back(m_if.data);
      rx_chan.push_back(m_if.chan);
      rx_first.push_back(m_if.first);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_chan_last    = frame_chan;
      fd_partial_last = frame_partial;
    end
    if (sel_err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic select(input int idx);
    ssel_n[idx] = 1'b0;
    tick(HALF);
  endtask

  task automatic deselect();
    tick(HALF);
    ssel_n = '1;
    tick(12);
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_chan.delete();
    rx_first.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({m_if.valid, m_if.data, m_if.chan, m_if.first} !== 11'b0) begin
      failures++;
      $display("FAIL reset_stream got=%h want=0", {m_if.valid, m_if.data, m_if.chan, m_if.first});
    end
    checks++;
    if ({frame_done, frame_chan, frame_partial, sel_err, ovf} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {frame_done, frame_chan, frame_partial, sel_err, ovf});
    end
    checks++;
    if (fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL reset_level got=%0d want=0", fifo_level);
    end
    rst_n = 1'b1;
    tick(5);
    checks++;
    if ({m_if.valid, fifo_level, frame_done, sel_err} !== 8'b0) begin
      failures++;
      $display("FAIL post_reset_idle got=%b want=0", {m_if.valid, fifo_level, frame_done, sel_err});
    end
  endtask

  task automatic test_frame_sel0();
    int fd0;
    clear_rx();
    fd0 = fd_cnt;
    m_if.ready = 1'b1;
    select(0);
    for (int i = 0; i < 3; i++) spi_bits(pat[i], 8);
    deselect();
    checks++;
    if (rx_data.size() !== 3) begin
      failures++;
      $display("FAIL sel0_count got=%0d want=3", rx_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_data[i] !== pat[i] || rx_chan[i] !== 1'b0 || rx_first[i] !== (i == 0)) begin
        failures++;
        $display("FAIL sel0_word%0d got=%h/%b/%b want=%h/0/%b", i, rx_data[i], rx_chan[i], rx_first[i], pat[i], i == 0);
      end
    end
    checks++;
    if (fd_cnt !== fd0 + 1 || fd_chan_last !== 1'b0 || fd_partial_last !== 1'b0) begin
      failures++;
      $display("FAIL sel0_frame_done got=%0d/%b/%b want=%0d/0/0", fd_cnt - fd0, fd_chan_last, fd_partial_last, 1);
    end
  endtask

  task automatic test_frame_sel1();
    int fd0;
    clear_rx();
    fd0 = fd_cnt;
    m_if.ready = 1'b1;
    select(1);
    for (int i = 0; i < 6; i++) spi_bits(pat[i], 8);
    deselect();
    checks++;
    if (rx_data.size() !== 6) begin
      failures++;
      $display("FAIL sel1_count got=%0d want=6", rx_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rx_data[i] !== pat[i] || rx_chan[i] !== 1'b1 || rx_first[i] !== (i == 0)) begin
        failures++;
        $display("FAIL sel1_word%0d got=%h/%b/%b want=%h/1/%b", i, rx_data[i], rx_chan[i], rx_first[i], pat[i], i == 0);
      end
    end
    checks++;
    if (fd_cnt !== fd0 + 1 || fd_chan_last !== 1'b1 || fd_partial_last !== 1'b0) begin
      failures++;
      $display("FAIL sel1_frame_done got=%0d/%b/%b want=1/1/0", fd_cnt - fd0, fd_chan_last, fd_partial_last);
    end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    int   n;
    bit   seen;
    b = 8'h3C;
    m_if.ready = 1'b0;
    select(0);
    spi_bits(b, 7);
    mosi = b[0];
    tick(HALF);
    sck  = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge CLOCK_50);
      n++;
      @(negedge CLOCK_50);
      if (m_if.valid) seen = 1'b1;
    end
    checks++;
    if (n !== SYNC_STAGES + 3) begin
      failures++;
      $display("FAIL word_latency got=%0d want=%0d", n, SYNC_STAGES + 3);
    end
    tick(HALF);
    sck = 1'b0;
    checks++;
    if (m_if.data !== 8'h3C || m_if.first !== 1'b1 || fifo_level !== 5'd1) begin
      failures++;
      $display("FAIL latency_word got=%h/%b/%0d want=3c/1/1", m_if.data, m_if.first, fifo_level);
    end
    tick(HALF);
    ssel_n = '1;
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge CLOCK_50);
      n++;
      @(negedge CLOCK_50);
      if (frame_done) seen = 1'b1;
    end
    checks++;
    if (n !== SYNC_STAGES + 2) begin
      failures++;
      $display("FAIL frame_done_latency got=%0d want=%0d", n, SYNC_STAGES + 2);
    end
    tick(4);
    clear_rx();
    m_if.ready = 1'b1;
    tick(3);
    checks++;
    if (rx_data.size() !== 1 || fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL latency_drain got=%0d/%0d want=1/0", rx_data.size(), fifo_level);
    end
  endtask

  task automatic test_overflow();
    clear_rx();
    m_if.ready = 1'b0;
    select(0);
    for (int i = 0; i < 18; i++) spi_bits(8'(i), 8);
    deselect();
    checks++;
    if (fifo_level !== 5'd16 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full got=%0d/%b want=16/1", fifo_level, ovf);
    end
    m_if.ready = 1'b1;
    tick(15);
    checks++;
    if (fifo_level !== 5'd1) begin
      failures++;
      $display("FAIL drain_rate got=%0d want=1", fifo_level);
    end
    tick(1);
    checks++;
    if (fifo_level !== 5'd0 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL drain_done got=%0d/%b want=0/1", fifo_level, ovf);
    end
    checks++;
    if (rx_data.size() !== 16) begin
      failures++;
      $display("FAIL ovf_count got=%0d want=16", rx_data.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rx_data[i] !== 8'(i) || rx_first[i] !== (i == 0)) begin
        failures++;
        $display("FAIL ovf_word%0d got=%h/%b want=%h/%b", i, rx_data[i], rx_first[i], 8'(i), i == 0);
      end
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got=%b want=0", ovf);
    end
  endtask

  task automatic test_partial();
    int fd0;
    clear_rx();
    fd0 = fd_cnt;
    m_if.ready = 1'b1;
    select(0);
    spi_bits(8'hA0, 5);
    deselect();
    checks++;
    if (rx_data.size() !== 0 || fifo_level !== 5'd0) begin
      failures++;
      $display("FAIL partial_words got=%0d/%0d want=0/0", rx_data.size(), fifo_level);
    end
    checks++;
    if (fd_cnt !== fd0 + 1 || fd_partial_last !== 1'b1 || fd_chan_last !== 1'b0) begin
      failures++;
      $display("FAIL partial_frame_done got=%0d/%b/%b want=1/1/0", fd_cnt - fd0, fd_partial_last, fd_chan_last);
    end
  endtask

  task automatic test_sel_err();
    int fd0, e0;
    clear_rx();
    fd0 = fd_cnt;
    e0  = err_cnt;
    m_if.ready = 1'b1;
    select(0);
    spi_bits(8'hF0, 4);
    ssel_n[1] = 1'b0;
    tick(HALF);
    spi_bits(8'hF0, 4);
    tick(HALF);
    ssel_n = '1;
    tick(12);
    checks++;
    if (err_cnt !== e0 + 1 || fd_cnt !== fd0 || rx_data.size() !== 0) begin
      failures++;
      $display("FAIL sel_err got=err%0d/fd%0d/words%0d want=1/0/0", err_cnt - e0, fd_cnt - fd0, rx_data.size());
    end
    select(0);
    spi_bits(8'h55, 8);
    deselect();
    checks++;
    if (rx_data.size() !== 1 || rx_data[0] !== 8'h55 || rx_chan[0] !== 1'b0 || rx_first[0] !== 1'b1) begin
      failures++;
      $display("FAIL after_err_word got=%0d:%h/%b/%b want=1:55/0/1", rx_data.size(), rx_data[0], rx_chan[0], rx_first[0]);
    end
    checks++;
    if (fd_cnt !== fd0 + 1 || fd_partial_last !== 1'b0) begin
      failures++;
      $display("FAIL after_err_frame got=%0d/%b want=1/0", fd_cnt - fd0, fd_partial_last);
    end
  endtask

  task automatic test_reset_midword();
    clear_rx();
    m_if.ready = 1'b0;
    select(0);
    spi_bits(8'h11, 8);
    spi_bits(8'h22, 8);
    spi_bits(8'h33, 8);
    spi_bits(8'hFF, 3);
    checks++;
    if (fifo_level !== 5'd3) begin
      failures++;
      $display("FAIL pre_reset_level got=%0d want=3", fifo_level);
    end
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ({m_if.valid, m_if.data, m_if.chan, m_if.first, fifo_level} !== 16'b0) begin
      failures++;
      $display("FAIL midword_reset_stream got=%h want=0", {m_if.valid, m_if.data, m_if.chan, m_if.first, fifo_level});
    end
    checks++;
    if ({frame_done, frame_chan, frame_partial, sel_err, ovf} !== 5'b0) begin
      failures++;
      $display("FAIL midword_reset_flags got=%b want=00000", {frame_done, frame_chan, frame_partial, sel_err, ovf});
    end
    ssel_n = '1;
    sck    = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    clear_rx();
    m_if.ready = 1'b1;
    select(0);
    spi_bits(8'hAA, 8);
    deselect();
    checks++;
    if (rx_data.size() !== 1 || rx_data[0] !== 8'hAA || rx_chan[0] !== 1'b0 || rx_first[0] !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_word got=%0d:%h/%b/%b want=1:aa/0/1", rx_data.size(), rx_data[0], rx_chan[0], rx_first[0]);
    end
  endtask

  initial begin
    m_if.ready = 1'b0;
    test_reset();
    test_frame_sel0();
    test_frame_sel1();
    test_latency();
    test_overflow();
    test_partial();
    test_sel_err();
    test_reset_midword();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_rx_slave_mc.md
# spi_rx_slave_mc

Parametrised multi-select SPI receive slave for the SPI-to-NeoPixel datapath. It oversamples the external SCK, MOSI and NUM_SEL active-low selects in the CLOCK_50 domain and assembles WORD_W-bit words. Each word is tagged with the index of the select that framed it and buffered in a first-word-fall-through FIFO. It replaces per-channel fixed 8-bit receivers and feeds the pixel-stream formatters through a valid/ready port.

## Interface
- NUM_SEL, 2, number of chip-select inputs / channels (1..8)
- WORD_W, 8, bits per received word (4..32)
- FIFO_DEPTH, 16, entries in word FIFO, power of two ≥ 2
- MSB_FIRST, 1, 1 = first bit shifted in lands in data[WORD_W-1]; 0 = lands in data[0]
- SYNC_STAGES, 2, synchroniser flops on sck/mosi/ssel_n (≥ 2)
- CLOCK_50  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- sck  in  1  SPI clock, mode 0 (idle low, sample on rising edge)
- mosi  in  1  SPI data
- ssel_n  in  NUM_SEL  active-low selects
- m_valid  out  1  FIFO head valid
- m_ready  in  1  consumer accepts head
- m_data  out  WORD_W  head word
- m_chan  out  max(1,clog2(NUM_SEL))  select index of head word
- m_first  out  1  head is first word of its frame
- frame_done  out  1  one-cycle pulse when the active select deasserts
- frame_chan  out  max(1,clog2(NUM_SEL))  channel of frame_done
- frame_partial  out  1  valid with frame_done: partial word discarded
- sel_err  out  1  one-cycle pulse on entering ERROR
- ovf  out  1  sticky: a word was dropped because FIFO was full
- ovf_clr  in  1  clears ovf
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Inputs pass through SYNC_STAGES flops; one further register gives previous values for edge detection. All decisions use synchronised signals only.
- States:
  - IDLE: all selects high.
  - ACTIVE: exactly one select low.
  - ERROR: more than one select low.
- IDLE -> ACTIVE when exactly one select goes low. Latch its index, clear the bit counter and shift register, and set the first flag.
- IDLE or ACTIVE -> ERROR when more than one select is low. Pulse sel_err and ignore SCK. A partial word is discarded with no frame_done.
- ERROR -> IDLE only when all selects are high.
- ACTIVE -> IDLE when the latched select goes high. Pulse frame_done with frame_chan, and set frame_partial = (bit counter ≠ 0). The partial word is discarded.
- In ACTIVE, each synchronised SCK rising edge shifts in MOSI per MSB_FIRST and increments the bit counter.
- On the WORD_W-th bit, the next cycle pushes {word, chan, first} into the FIFO. The counter wraps to 0 and the first flag clears.
- Push into a full FIFO drops the word and sets ovf. A simultaneous pop and push when full is accepted with no overflow.
- ovf_clr in the same cycle as a new overflow leaves ovf = 1.
- Pop occurs when m_valid && m_ready. m_data, m_chan and m_first are stable while m_valid = 1 and m_ready = 0.
- Select falling edge and SCK edge in the same cycle: the select is processed first. The SCK edge is ignored because no valid bit precedes select assertion in mode 0.
- Reset (any time, including mid-word):
  - state = IDLE; FIFO emptied.
  - m_valid, m_data, m_chan, m_first = 0.
  - frame_done, frame_chan, frame_partial, sel_err, ovf = 0; fifo_level = 0.
  - Synchronisers reset to sck = 0, ssel_n all ones.

## Timing
- SCK high and low phases must each last ≥ SYNC_STAGES+2 CLOCK_50 periods. Slower SCK is unrestricted.
- Select setup before the first SCK rising edge must be ≥ SYNC_STAGES+2 periods. Hold after the last falling edge is the same.
- Latency from the final-bit SCK rising edge at the pin to m_valid (FIFO empty, m_ready don't-care) is exactly SYNC_STAGES+3 cycles.
- frame_done asserts SYNC_STAGES+2 cycles after ssel_n rises at the pin.
- fifo_level updates in the cycle following a push or pop.
- Throughput: one pop per cycle while m_ready = 1.

## Test plan
- Select 0 low, send 0xAA, 0x55, 0x00, then raise select:
  - Three words with m_chan = 0 and m_first = 1 only on 0xAA.
  - frame_done with frame_chan = 0 and frame_partial = 0.
- Repeat on select 1 with 0xAA, 0x55, 0x00, 0xAA, 0x55, 0x00 -> six words with m_chan = 1, data in that order.
- Hold m_ready = 0 and send 18 bytes 0x00..0x11:
  - fifo_level saturates at 16 and ovf = 1.
  - Draining yields 0x00..0x0F.
  - ovf_clr clears ovf.
- Raise select after 5 bits -> no word pushed, and frame_done with frame_partial = 1.
- Drive both selects low mid-byte:
  - sel_err pulses and no words are produced.
  - After both go high, a select-0 frame with 0x55 is received cleanly with m_first = 1.
- Assert rst_n = 0 mid-word with the FIFO holding 3 words:
  - All outputs = 0 and fifo_level = 0.
  - The next frame 0xAA is received correctly.
